// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM state encoding and small helpers shared by the
// sequential ALU (alu_seq) and its iterative multiplier (alu_mul_iter).
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SHR = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_SHL = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // True for the two variable-shift opcodes
    function automatic logic isShift(input logic [2:0] op);
        return (op == OP_SHR) || (op == OP_SHL);
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: N-iteration shift-add multiplier. A start pulse loads the
// operands; one partial product is accumulated per cycle. o_done is high
// during the last iteration and o_product then already includes that last
// partial product, so the caller can latch it on the same edge.
module alu_mul_iter #(
    parameter int N  = 16,
    parameter int CW = $clog2(N) + 1
) (
    input  logic           i_clk,
    input  logic           i_reset,
    input  logic           i_start,
    input  logic [N-1:0]   i_a,
    input  logic [N-1:0]   i_b,
    output logic           o_done,
    output logic [2*N-1:0] o_product
);

    logic [2*N-1:0] r_mcand;
    logic [N-1:0]   r_mplier;
    logic [2*N-1:0] r_acc;
    logic [CW-1:0]  r_cnt;
    logic           r_busy;
    logic [2*N-1:0] w_accNext;

    assign w_accNext = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign o_done    = r_busy && (r_cnt == CW'(1));
    assign o_product = w_accNext;

    // Load on start, then shift the multiplicand left and the multiplier right each iteration
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
        end else if (i_start) begin
            r_mcand  <= {{N{1'b0}}, i_a};
            r_mplier <= i_b;
            r_acc    <= '0;
            r_cnt    <= CW'(N);
            r_busy   <= 1'b1;
        end else if (r_busy) begin
            r_acc    <= w_accNext;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with valid/ready handshakes on both sides.
// add/sub/logic and shift-by-0 finish on the accept edge; variable shifts
// take one extra cycle per bit; multiply takes N extra cycles.
// Build option: define ALU_MUL_EN to enable the iterative multiplier;
// without it opcode 111 completes at once with q=0.
module alu_seq
    import alu_pkg::*;
#(
    parameter int N   = 16,
    parameter int SHW = $clog2(N)
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic [2:0]   i_control,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [N-1:0] q,
    output logic         mayor,
    output logic         paridad,
    output logic         cero
);

    state_t           r_state;
    logic             r_ready;
    logic             r_valid;
    logic [2:0]       r_op;
    logic [N-1:0]     r_sh;
    logic [SHW-1:0]   r_cnt;

    logic [N:0]       w_sum;
    logic [N-1:0]     w_res;
    logic             w_mayor;
    logic [SHW-1:0]   w_amt;
    logic             w_multi;
    logic [N-1:0]     w_shNext;
    logic             w_shOut;

    assign o_ready = r_ready;
    assign o_valid = r_valid;
    assign w_sum   = {1'b0, i_a} + {1'b0, i_b};
    assign w_amt   = i_b[SHW-1:0];

`ifdef ALU_MUL_EN
    logic             w_mulStart;
    logic             w_mulDone;
    logic [2*N-1:0]   w_product;

    assign w_multi    = (isShift(i_control) && (w_amt != '0)) || (i_control == OP_MUL);
    assign w_mulStart = (r_state == ST_IDLE) && i_valid && (i_control == OP_MUL);

    alu_mul_iter #(.N(N)) u_mul (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_start   (w_mulStart),
        .i_a       (i_a),
        .i_b       (i_b),
        .o_done    (w_mulDone),
        .o_product (w_product)
    );
`else
    assign w_multi = isShift(i_control) && (w_amt != '0);
`endif

    // Single-cycle result and flag from the live operands, used on the accept edge
    always_comb begin
        w_res   = '0;
        w_mayor = 1'b0;
        case (i_control)
            OP_ADD: begin
                w_res   = w_sum[N-1:0];
                w_mayor = w_sum[N];
            end
            OP_SUB: begin
                w_res   = i_a - i_b;
                w_mayor = (i_a > i_b);
            end
            OP_SHR, OP_SHL: w_res = i_a;
            OP_AND: w_res = i_a & i_b;
            OP_OR:  w_res = i_a | i_b;
            OP_XOR: w_res = i_a ^ i_b;
            default: ;
        endcase
    end

    // One-bit shift step applied to the working register while BUSY
    always_comb begin
        w_shNext = r_sh >> 1;
        w_shOut  = r_sh[0];
        if (r_op == OP_SHL) begin
            w_shNext = r_sh << 1;
            w_shOut  = r_sh[N-1];
        end
    end

    // Handshake FSM with registered ready/valid, result and flags
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
            r_valid <= 1'b0;
            r_op    <= OP_ADD;
            r_sh    <= '0;
            r_cnt   <= '0;
            q       <= '0;
            mayor   <= 1'b0;
            paridad <= 1'b0;
            cero    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_valid) begin
                        r_op    <= i_control;
                        r_sh    <= i_a;
                        r_cnt   <= w_amt;
                        r_ready <= 1'b0;
                        if (w_multi) begin
                            r_state <= ST_BUSY;
                        end else begin
                            r_state <= ST_DONE;
                            r_valid <= 1'b1;
                            q       <= w_res;
                            mayor   <= w_mayor;
                            paridad <= w_res[0];
                            cero    <= (w_res == '0);
                        end
                    end
                end
                ST_BUSY: begin
`ifdef ALU_MUL_EN
                    if (r_op == OP_MUL) begin
                        if (w_mulDone) begin
                            r_state <= ST_DONE;
                            r_valid <= 1'b1;
                            q       <= w_product[N-1:0];
                            mayor   <= |w_product[2*N-1:N];
                            paridad <= w_product[0];
                            cero    <= (w_product[N-1:0] == '0);
                        end
                    end else
`endif
                    begin
                        r_sh  <= w_shNext;
                        r_cnt <= r_cnt - SHW'(1);
                        if (r_cnt == SHW'(1)) begin
                            r_state <= ST_DONE;
                            r_valid <= 1'b1;
                            q       <= w_shNext;
                            mayor   <= w_shOut;
                            paridad <= w_shNext[0];
                            cero    <= (w_shNext == '0);
                        end
                    end
                end
                ST_DONE: begin
                    if (i_ready) begin
                        r_state <= ST_IDLE;
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
